event_readout: RTL and testbench



---
 rtl/event_readout_if.sv | 10 +
 rtl/event_readout.sv | 140 ++++++++++++++
 tb/tb_event_readout.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_readout_if.sv
// Byte stream from the event readout to the UART transmitter.
// The master drives tx_data/tx_valid and the slave answers with tx_ready.
interface event_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/event_readout.sv
// Round-robin readout of per-channel event FIFOs into a framed byte stream.
// Each packet is a header byte followed by 8 payload bytes (MSB first), or a header-only overrun packet.
module event_readout #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCH-1:0]       i_ch_attention,
  input  logic [NCH-1:0]       i_ch_overrun,
  input  logic [8*NCH-1:0]     i_ch_data,
  output logic [2:0]           o_ch_byteaddr,
  output logic [NCH-1:0]       o_ch_unload,
  output logic [NCH-1:0]       o_ch_clearoverrun,
  output logic                 o_busy,
  event_readout_if.master      tx
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [2:0] {StIdle, StHdr, StLoad, StSend, StHold} state_e;

  state_e         r_state;
  logic [GW-1:0]  r_grant;
  logic [GW-1:0]  r_last;
  logic           r_ovf;
  logic [HW-1:0]  r_hold;
  logic [2:0]     r_byteaddr;
  logic [NCH-1:0] r_unload;
  logic [NCH-1:0] r_clear;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic           r_busy;

  logic [GW-1:0]  w_grant;
  logic [3:0]     w_g4;
  logic [NCH-1:0] w_onehot;
  logic [7:0]     w_bytes [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_bytes
    assign w_bytes[i] = i_ch_data[8*i +: 8];
  end

  // Walk from the farthest candidate back to last_grant+1 so the nearest set bit wins.
  always_comb begin
    w_grant = r_last;
    for (int k = NCH; k >= 1; k--) begin
      if (i_ch_attention[GW'((int'(r_last) + k) % NCH)]) begin
        w_grant = GW'((int'(r_last) + k) % NCH);
      end
    end
  end

  assign w_g4     = 4'(w_grant);
  assign w_onehot = NCH'(1) << r_grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_last     <= GW'(NCH - 1);
      r_ovf      <= 1'b0;
      r_hold     <= '0;
      r_byteaddr <= 3'd0;
      r_unload   <= '0;
      r_clear    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_unload <= '0;
      r_clear  <= '0;
      unique case (r_state)
        StIdle: begin
          if (|i_ch_attention) begin
            r_grant    <= w_grant;
            r_last     <= w_grant;
            r_ovf      <= i_ch_overrun[w_grant];
            r_tx_data  <= {i_ch_overrun[w_grant], 3'b000, w_g4};
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StHdr;
          end
        end
        StHdr: begin
          if (tx.tx_ready) begin
            r_tx_valid <= 1'b0;
            if (r_ovf) begin
              // Overrun packets are header only; the FIFO word stays for a later grant.
              r_clear <= w_onehot;
              r_hold  <= '0;
              r_state <= StHold;
            end else begin
              r_byteaddr <= 3'd7;
              r_state    <= StLoad;
            end
          end
        end
        StLoad: begin
          r_tx_data  <= w_bytes[r_grant];
          r_tx_valid <= 1'b1;
          r_state    <= StSend;
        end
        StSend: begin
          if (tx.tx_ready) begin
            r_tx_valid <= 1'b0;
            if (r_byteaddr != 3'd0) begin
              r_byteaddr <= r_byteaddr - 3'd1;
              r_state    <= StLoad;
            end else begin
              r_unload <= w_onehot;
              r_hold   <= '0;
              r_state  <= StHold;
            end
          end
        end
        StHold: begin
          // Holdoff lets the channel's delayed attention reflect the pop/clear before rearbitrating.
          r_byteaddr <= 3'd0;
          if (r_hold == HW'(HOLDOFF - 1)) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ch_byteaddr     = r_byteaddr;
  assign o_ch_unload       = r_unload;
  assign o_ch_clearoverrun = r_clear;
  assign o_busy            = r_busy;
  assign tx.tx_data        = r_tx_data;
  assign tx.tx_valid       = r_tx_valid;

endmodule

// File: tb/tb_event_readout.sv
// Bench for event_readout: channel FIFO model plus packet scoreboard, directed cases then random traffic.
module tb_event_readout;
  localparam int unsigned NCH     = 4;
  localparam int unsigned HOLDOFF = 2;
  localparam int unsigned DEPTH   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic [NCH-1:0]   att;
  logic [NCH-1:0]   ovr_sig;
  logic [8*NCH-1:0] ch_data;
  logic [2:0]       byteaddr;
  logic [NCH-1:0]   unload;
  logic [NCH-1:0]   clrovr;
  logic             busy;

  event_readout_if tx_if ();

  event_readout #(.NCH(NCH), .HOLDOFF(HOLDOFF)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .i_ch_attention    (att),
    .i_ch_overrun      (ovr_sig),
    .i_ch_data         (ch_data),
    .o_ch_byteaddr     (byteaddr),
    .o_ch_unload       (unload),
    .o_ch_clearoverrun (clrovr),
    .o_busy            (busy),
    .tx                (tx_if)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; logic [63:0] w;} req_t;

  // Channel model: FIFO of words, latched overrun, attention delayed one clock.
  logic [63:0] fifo [NCH][$];
  bit          ovr [NCH];
  logic [63:0] front [NCH];
  req_t        req_q[$];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_data[8*i +: 8] = front[i][{byteaddr, 3'b000} +: 8];
  end

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         lens[$];
  int         last_g, cur_g, busy_len, pulse_age;
  bit         cur_ovf, pend;
  bit         prev_busy = 0, prev_valid = 0, prev_ready = 0;
  logic [7:0] prev_data;
  logic [NCH-1:0] samp_att = '0, samp_ovr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr(input logic [NCH-1:0] a, input int last);
    for (int k = 1; k <= NCH; k++) begin
      if (((a >> ((last + k) % NCH)) & 1) != 0) return (last + k) % NCH;
    end
    return last;
  endfunction

  function automatic bit quiet();
    if (req_q.size() != 0 || exp_q.size() != 0 || busy) return 0;
    for (int i = 0; i < NCH; i++) if (fifo[i].size() != 0 || ovr[i]) return 0;
    return 1;
  endfunction

  task automatic push(input int ch, input logic [63:0] w);
    req_t r;
    r.ch = ch;
    r.w  = w;
    req_q.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    tx_if.tx_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Scoreboard first (uses inputs the DUT sampled last edge), then the channel model update.
  always @(negedge clk) begin
    logic [NCH-1:0] pre;
    logic [NCH-1:0] exp_u, exp_c;
    logic [7:0]     e;
    req_t           r;
    int             g;
    if (!rstn) begin
      chk("rst_valid", tx_if.tx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_unload", unload, 0);
      chk("rst_clear", clrovr, 0);
      chk("rst_byteaddr", byteaddr, 0);
      exp_q.delete();
      pend = 0; pulse_age = 0; last_g = NCH - 1; busy_len = 0;
      prev_busy = 0; prev_valid = 0;
    end else begin
      exp_u = (pend && !cur_ovf) ? (NCH'(1) << cur_g) : '0;
      exp_c = (pend &&  cur_ovf) ? (NCH'(1) << cur_g) : '0;
      chk("unload", unload, exp_u);
      chk("clearoverrun", clrovr, exp_c);
      if (pend) pulse_age = 1;
      else if (pulse_age == 1) begin chk("busy_in_hold", busy, 1); pulse_age = 2; end
      else if (pulse_age == 2) begin chk("busy_after_hold", busy, 0); pulse_age = 0; end
      pend = 0;
      if (busy && !prev_busy) begin
        chk("grant_attention", |samp_att, 1);
        g = rr(samp_att, last_g);
        last_g = g; cur_g = g; cur_ovf = samp_ovr[g];
        chk("grant_has_work", cur_ovf || fifo[g].size() != 0, 1);
        exp_q.push_back({cur_ovf, 3'b000, 4'(g)});
        if (!cur_ovf && fifo[g].size() != 0)
          for (int b = 7; b >= 0; b--) exp_q.push_back(fifo[g][0][8*b +: 8]);
        busy_len = 0;
      end
      if (busy) busy_len++;
      if (!busy && prev_busy) lens.push_back(busy_len);
      if (prev_valid && !prev_ready) begin
        chk("valid_held", tx_if.tx_valid, 1);
        chk("data_held", tx_if.tx_data, prev_data);
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h, expected no transfer", tx_if.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", tx_if.tx_data, e);
          if (exp_q.size() == 0) pend = 1;
        end
        got.push_back(tx_if.tx_data);
      end
      prev_busy = busy; prev_valid = tx_if.tx_valid;
      prev_ready = tx_if.tx_ready; prev_data = tx_if.tx_data;
    end
    for (int i = 0; i < NCH; i++) pre[i] = (fifo[i].size() != 0) || ovr[i];
    if (rstn) begin
      for (int i = 0; i < NCH; i++) begin
        if (unload[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        if (clrovr[i]) ovr[i] = 0;
      end
    end
    while (req_q.size() != 0) begin
      r = req_q.pop_front();
      if (fifo[r.ch].size() >= DEPTH) ovr[r.ch] = 1;
      else fifo[r.ch].push_back(r.w);
    end
    for (int i = 0; i < NCH; i++) begin
      front[i]   = (fifo[i].size() != 0) ? fifo[i][0] : 64'h0;
      ovr_sig[i] = ovr[i];
    end
    att = pre;
    samp_att = att;
    samp_ovr = ovr_sig;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (4) @(posedge clk);
    #1;
    while (!quiet() && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    got.delete();
    lens.delete();
  endtask

  task automatic chk_word(input string name, input int base, input logic [7:0] hdr,
                          input logic [63:0] w);
    chk({name, "_hdr"}, got[base], hdr);
    for (int b = 0; b < 8; b++) chk({name, "_pay"}, got[base + 1 + b], w[8*(7-b) +: 8]);
  endtask

  logic [7:0] t1_exp [9] = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] t5_exp [9] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    for (int i = 0; i < NCH; i++) begin ovr[i] = 0; front[i] = '0; end
    att = '0; ovr_sig = '0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single channel, ready high.
    got.delete(); lens.delete();
    push(1, 64'h0123456789ABCDEF);
    wait_idle(400);
    chk("t1_nbytes", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t1_byte", got[i], t1_exp[i]);
    chk("t1_npackets", lens.size(), 1);
    if (lens.size() > 0) chk("t1_busy_cycles", lens[0], 19);

    // Round-robin between channels 0 and 2.
    do_reset();
    push(0, 64'hA0A0A0A0A0A0A0A0); push(0, 64'hA1A1A1A1A1A1A1A1);
    push(2, 64'hB0B0B0B0B0B0B0B0); push(2, 64'hB1B1B1B1B1B1B1B1);
    wait_idle(800);
    chk("t2_nbytes", got.size(), 36);
    if (got.size() == 36) begin
      chk("t2_hdr0", got[0], 8'h00);
      chk("t2_hdr1", got[9], 8'h02);
      chk("t2_hdr2", got[18], 8'h00);
      chk("t2_hdr3", got[27], 8'h02);
      chk("t2_pay1", got[10], 8'hB0);
    end

    // Overrun on channel 3: header-only packet, then data packets.
    do_reset();
    push(3, 64'hFEDCBA9876543210); push(3, 64'h1111111111111111); push(3, 64'h2222222222222222);
    push(3, 64'h3333333333333333); push(3, 64'h4444444444444444);
    wait_idle(800);
    chk("t3_nbytes", got.size(), 37);
    if (got.size() == 37) begin
      chk("t3_ovf_hdr", got[0], 8'h83);
      chk("t3_data_hdr", got[1], 8'h03);
      chk("t3_first_pay", got[2], 8'hFE);
      chk_word("t3_w0", 1, 8'h03, 64'hFEDCBA9876543210);
      chk_word("t3_w3", 28, 8'h03, 64'h3333333333333333);
    end
    if (lens.size() >= 2) begin
      chk("t3_ovf_cycles", lens[0], 3);
      chk("t3_data_cycles", lens[1], 19);
    end else chk("t3_npackets", lens.size(), 5);

    // Same single-channel word with a stalling sink.
    do_reset();
    rdy_mode = 1;
    push(1, 64'h0123456789ABCDEF);
    wait_idle(800);
    rdy_mode = 0;
    chk("t4_nbytes", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t4_byte", got[i], t1_exp[i]);

    // Reset in the middle of the payload; the word must be resent whole.
    do_reset();
    push(2, 64'h1122334455667788);
    begin
      int n = 0;
      while (got.size() < 5 && n < 200) begin @(negedge clk); #1; n++; end
      chk("t5_reached_payload", got.size() >= 5, 1);
    end
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_valid", tx_if.tx_valid, 0);
    chk("t5_async_data", tx_if.tx_data, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_addr", byteaddr, 0);
    chk("t5_async_unload", unload, 0);
    chk("t5_async_clear", clrovr, 0);
    repeat (2) @(posedge clk);
    got.delete();
    #2 rstn = 1'b1;
    wait_idle(400);
    chk("t5_nbytes", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t5_byte", got[i], t5_exp[i]);

    // Random traffic with stalls and occasional overflow bursts.
    do_reset();
    rdy_mode = 1;
    for (int it = 0; it < 80; it++) begin
      int ch;
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      ch = int'($urandom_range(0, NCH - 1));
      push(ch, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) begin
        push(ch, {$urandom, $urandom});
        push(ch, {$urandom, $urandom});
        push(ch, {$urandom, $urandom});
      end
    end
    wait_idle(6000);
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
